// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped controller for one bank of bidirectional pad cells.
// Drives per-pad configuration and output data, synchronizes the returned pad
// values, and latches qualified rising/falling edges into a sticky STATUS
// register that feeds a registered level interrupt.
module gpio_ctrl #(
  parameter int NUM_PINS   = 8,
  parameter int CONF_WIDTH = 3,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             req_in,
  input  logic                             we_in,
  input  logic [ADDR_WIDTH-1:0]            addr_in,
  input  logic [31:0]                      wdata_in,
  output logic [31:0]                      rdata_out,
  output logic                             rvalid_out,
  output logic [NUM_PINS*CONF_WIDTH-1:0]   io_cell_cfg_out,
  output logic [NUM_PINS-1:0]              from_core_out,
  input  logic [NUM_PINS-1:0]              to_core_in,
  output logic                             irq_out
);

  // Width of the per-pad option field (cfg bits above the direction bit).
  localparam int PW = (CONF_WIDTH > 1) ? CONF_WIDTH - 1 : 1;

  localparam logic [ADDR_WIDTH-1:0] A_DIR     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_OUT     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_IN      = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_RISE_EN = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_FALL_EN = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(5);
  localparam int                    PINCFG_BASE = 8;

  logic                wr_en;
  logic                rd_en;
  logic [NUM_PINS-1:0] wdata_pins;
  logic                unused_wdata;

  assign wr_en        = req_in & we_in;
  assign rd_en        = req_in & ~we_in;
  assign wdata_pins   = wdata_in[NUM_PINS-1:0];
  assign unused_wdata = ^wdata_in;

  logic [NUM_PINS-1:0] dir_q, dir_d;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
  logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
  logic [NUM_PINS-1:0] status_q, status_d;
  logic [NUM_PINS-1:0] s1_q, s2_q, s3_q;
  logic [NUM_PINS-1:0] edge_q, edge_d;
  logic                irq_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q;
  logic [NUM_PINS*PW-1:0] pincfg_flat;

  // Bank-wide register writes; STATUS is W1C with a new edge winning over a clear.
  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    if (wr_en) begin
      case (addr_in)
        A_DIR:     dir_d     = wdata_pins;
        A_OUT:     out_d     = wdata_pins;
        A_RISE_EN: rise_en_d = wdata_pins;
        A_FALL_EN: fall_en_d = wdata_pins;
        A_STATUS:  status_d  = status_q & ~wdata_pins;
        default:   ;
      endcase
    end
    status_d = status_d | edge_q;
  end

  // Read mux; unmapped addresses and non-read cycles yield zero.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (addr_in)
        A_DIR:     rdata_d = 32'(dir_q);
        A_OUT:     rdata_d = 32'(out_q);
        A_IN:      rdata_d = 32'(s2_q);
        A_RISE_EN: rdata_d = 32'(rise_en_q);
        A_FALL_EN: rdata_d = 32'(fall_en_q);
        A_STATUS:  rdata_d = 32'(status_q);
        default:   ;
      endcase
      for (int i = 0; i < NUM_PINS; i++) begin
        if (addr_in == ADDR_WIDTH'(PINCFG_BASE + i)) begin
          rdata_d = 32'(pincfg_flat[i*PW +: PW]);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      logic [PW-1:0] pincfg_q;
      logic [1:0]    mask_q, mask_d;
      logic          pin_sel;
      logic          rise, fall;

      assign pin_sel = wr_en && (addr_in == ADDR_WIDTH'(PINCFG_BASE + gi));
      assign rise    = s2_q[gi] & ~s3_q[gi];
      assign fall    = ~s2_q[gi] & s3_q[gi];

      // An edge qualifies only in input mode, outside the post-turnaround mask window.
      assign edge_d[gi] = ~dir_q[gi] && (mask_q == 2'd0) &&
                          ((rise && rise_en_q[gi]) || (fall && fall_en_q[gi]));

      // Mask counter reloads on an output->input turnaround and counts down to 0.
      always_comb begin
        mask_d = mask_q;
        if (dir_q[gi] && !dir_d[gi]) begin
          mask_d = 2'd3;
        end else if (mask_q != 2'd0) begin
          mask_d = mask_q - 2'd1;
        end
      end

      // Per-pad option register and mask counter state.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          pincfg_q <= '0;
          mask_q   <= '0;
        end else begin
          if (pin_sel) pincfg_q <= wdata_in[PW-1:0];
          mask_q <= mask_d;
        end
      end

      assign pincfg_flat[gi*PW +: PW] = pincfg_q;

      if (CONF_WIDTH > 1) begin : g_cfg
        assign io_cell_cfg_out[gi*CONF_WIDTH +: CONF_WIDTH] = {pincfg_q, ~dir_q[gi]};
      end else begin : g_cfg_dir_only
        assign io_cell_cfg_out[gi] = ~dir_q[gi];
      end
    end
  endgenerate

  // Bank registers, synchronizer chain, edge stage, interrupt and read response.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      edge_q    <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      s1_q      <= to_core_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      edge_q    <= edge_d;
      irq_q     <= |status_q;
      rdata_q   <= rdata_d;
      rvalid_q  <= rd_en;
    end
  end

  assign from_core_out = out_q;
  assign irq_out       = irq_q;
  assign rdata_out     = rdata_q;
  assign rvalid_out    = rvalid_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: table-driven register checks plus hand-written sequences for
// input synchronization, edge interrupts, set/clear collision, direction mask
// and mid-operation reset.
module tb_gpio_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [23:0] cfg;
  logic [7:0]  from_core;
  logic [7:0]  to_core;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  gpio_ctrl #(.NUM_PINS(8), .CONF_WIDTH(3), .ADDR_WIDTH(6)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .req_in          (req),
    .we_in           (we),
    .addr_in         (addr),
    .wdata_in        (wdata),
    .rdata_out       (rdata),
    .rvalid_out      (rvalid),
    .io_cell_cfg_out (cfg),
    .from_core_out   (from_core),
    .to_core_in      (to_core),
    .irq_out         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [23:0] exp_cfg;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling clock edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    $display("wr  addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string name);
    req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    $display("rd  addr=0x%02h data=0x%08h rvalid=%0b", a, rdata, rvalid);
    check({name, "_rvalid"}, 32'(rvalid), 32'd1);
    check(name, rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 6'h00, 32'h0,        32'h00, 24'h249249, 8'h00};
    vecs[1]  = '{1'b1, 6'h00, 32'hA5,       32'h00, 24'h041208, 8'h00};
    vecs[2]  = '{1'b1, 6'h01, 32'hFF,       32'h00, 24'h041208, 8'hFF};
    vecs[3]  = '{1'b1, 6'h0B, 32'h2,        32'h00, 24'h041A08, 8'hFF};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,        32'hA5, 24'h041A08, 8'hFF};
    vecs[5]  = '{1'b0, 6'h01, 32'h0,        32'hFF, 24'h041A08, 8'hFF};
    vecs[6]  = '{1'b0, 6'h0B, 32'h0,        32'h02, 24'h041A08, 8'hFF};
    vecs[7]  = '{1'b1, 6'h01, 32'hFFFFFF0F, 32'h00, 24'h041A08, 8'h0F};
    vecs[8]  = '{1'b0, 6'h01, 32'h0,        32'h0F, 24'h041A08, 8'h0F};
    vecs[9]  = '{1'b0, 6'h07, 32'h0,        32'h00, 24'h041A08, 8'h0F};
    vecs[10] = '{1'b1, 6'h06, 32'hFF,       32'h00, 24'h041A08, 8'h0F};
    vecs[11] = '{1'b0, 6'h3F, 32'h0,        32'h00, 24'h041A08, 8'h0F};
    vecs[12] = '{1'b1, 6'h0F, 32'hFF,       32'h00, 24'hC41A08, 8'h0F};
    vecs[13] = '{1'b0, 6'h0F, 32'h0,        32'h03, 24'hC41A08, 8'h0F};
    vecs[14] = '{1'b0, 6'h10, 32'h0,        32'h00, 24'hC41A08, 8'h0F};
    vecs[15] = '{1'b1, 6'h03, 32'h81,       32'h00, 24'hC41A08, 8'h0F};
    vecs[16] = '{1'b0, 6'h03, 32'h0,        32'h81, 24'hC41A08, 8'h0F};
    vecs[17] = '{1'b1, 6'h04, 32'h42,       32'h00, 24'hC41A08, 8'h0F};
    vecs[18] = '{1'b0, 6'h04, 32'h0,        32'h42, 24'hC41A08, 8'h0F};
    vecs[19] = '{1'b0, 6'h02, 32'h0,        32'h00, 24'hC41A08, 8'h0F};
    vecs[20] = '{1'b0, 6'h05, 32'h0,        32'h00, 24'hC41A08, 8'h0F};
    vecs[21] = '{1'b1, 6'h00, 32'h0,        32'h00, 24'hE49A49, 8'h0F};
    vecs[22] = '{1'b1, 6'h01, 32'h0,        32'h00, 24'hE49A49, 8'h00};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; to_core = '0;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_cfg", 32'(cfg), 32'h249249);
    check("reset_out", 32'(from_core), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_rdata", rdata, 32'h0);

    // Back-to-back register transactions from the table.
    for (int i = 0; i < 23; i++) begin
      req = 1'b1; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      @(posedge clk);
      @(negedge clk);
      $display("vec %0d we=%0b addr=0x%02h wdata=0x%08h rdata=0x%08h rvalid=%0b cfg=0x%06h out=0x%02h",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, rvalid, cfg, from_core);
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(!vecs[i].we));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_cfg", i), 32'(cfg), 32'(vecs[i].exp_cfg));
      check($sformatf("vec%0d_out", i), 32'(from_core), 32'(vecs[i].exp_out));
    end
    req = 1'b0; we = 1'b0;
    idle(1);
    check("idle_rvalid", 32'(rvalid), 32'h0);
    check("idle_rdata", rdata, 32'h0);

    // Input synchronizer: pad changes before edge k; reads sampled at k, k+1, k+2.
    to_core = 8'h3C;
    rd(6'h02, 32'h00, "in_at_k");
    rd(6'h02, 32'h00, "in_at_k1");
    rd(6'h02, 32'h3C, "in_at_k2");
    rd(6'h02, 32'h3C, "in_at_k3");
    rd(6'h05, 32'h00, "in_status_none");
    to_core = 8'h00;
    idle(5);

    // Edge interrupt: pin0 rises, pin1 falls.
    wr(6'h03, 32'h01);
    wr(6'h04, 32'h02);
    to_core = 8'h02;
    idle(6);
    rd(6'h05, 32'h00, "edge_pre_status");
    to_core = 8'h01;
    idle(3);
    rd(6'h05, 32'h00, "edge_status_k3_preset");
    check("edge_irq_k3", 32'(irq), 32'h0);
    rd(6'h05, 32'h03, "edge_status");
    check("edge_irq_k4", 32'(irq), 32'h1);
    wr(6'h05, 32'h01);
    rd(6'h05, 32'h02, "w1c_partial");
    check("w1c_partial_irq", 32'(irq), 32'h1);
    wr(6'h05, 32'h02);
    check("w1c_irq_same", 32'(irq), 32'h1);
    idle(1);
    check("w1c_irq_drop", 32'(irq), 32'h0);

    // Set/clear collision on pin0: the edge wins.
    to_core = 8'h00;
    idle(5);
    rd(6'h05, 32'h00, "coll_pre_status");
    to_core = 8'h01;
    idle(3);
    wr(6'h05, 32'h01);
    rd(6'h05, 32'h01, "coll_status");
    wr(6'h03, 32'h00);
    rd(6'h05, 32'h01, "en_clear_keeps_status");
    check("coll_irq", 32'(irq), 32'h1);
    wr(6'h05, 32'hFF);
    idle(2);
    rd(6'h05, 32'h00, "coll_cleared");
    check("coll_irq_clear", 32'(irq), 32'h0);

    // Direction-change mask on pin0.
    wr(6'h03, 32'h01);
    wr(6'h00, 32'h01);
    idle(3);
    wr(6'h00, 32'h00);
    idle(5);
    rd(6'h05, 32'h00, "mask_held_high");
    wr(6'h00, 32'h01);
    to_core = 8'h00;
    idle(5);
    to_core = 8'h01;
    idle(6);
    rd(6'h05, 32'h00, "dir_out_blocks_edge");
    to_core = 8'h00;
    idle(5);
    to_core = 8'h01;
    wr(6'h00, 32'h00);
    idle(8);
    rd(6'h05, 32'h00, "mask_stale_edge");
    to_core = 8'h00;
    idle(5);
    to_core = 8'h01;
    idle(6);
    rd(6'h05, 32'h01, "mask_real_edge");
    check("mask_real_irq", 32'(irq), 32'h1);

    // Reset mid-operation with a read request in the same cycle.
    wr(6'h01, 32'h5A);
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 6'h05;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    $display("rst mid-op with read of 0x05");
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_cfg", 32'(cfg), 32'h249249);
    check("midrst_out", 32'(from_core), 32'h0);
    rd(6'h05, 32'h00, "midrst_status");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
